crc_append: RTL and testbench

- Parametrised transmit-side CRC appender for byte streams.
- Next generation of the fixed Ethernet-CRC appender: CRC width, polynomial, init, output XOR and bit order are configurable, short payloads are zero-padded to a minimum length, and packets can bypass CRC.
- Sits between the packet source and the PHY-side byte serializer. Advances only on i_ce strobes.

---
 rtl/crc_append.sv | 157 +++++++++++++++
 tb/tb_crc_append.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_append.sv
// crc_append: configurable pad+CRC appender (i_clk,i_reset_n,i_ce,i_en,i_v,i_d -> o_v,o_d,o_busy,o_overrun; CRC_APPEND_STATUS_EN adds o_done,o_len)
module crc_append #(
  parameter int          CRC_BITS    = 32,
  parameter logic [31:0] POLY        = 32'h04c1_1db7,
  parameter logic [31:0] INIT        = 32'hffff_ffff,
  parameter logic [31:0] XOROUT      = 32'hffff_ffff,
  parameter bit          REFLECT     = 1'b1,
  parameter int          MIN_PAYLOAD = 60,
  parameter int          LGMAXLEN    = 11
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_busy,
  output logic       o_overrun
`ifdef CRC_APPEND_STATUS_EN
  ,
  output logic                o_done,
  output logic [LGMAXLEN-1:0] o_len
`endif
);
  localparam int W = CRC_BITS;
  localparam int NB = W / 8;
  localparam int IW = $clog2(NB + 1);
  localparam logic [W-1:0] P = POLY[W-1:0];
  localparam logic [W-1:0] I = INIT[W-1:0];
  localparam logic [W-1:0] XO = XOROUT[W-1:0];
  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction
  localparam logic [W-1:0] RP = rev(P);
  function automatic logic [W-1:0] crc_upd(input logic [W-1:0] c, input logic [7:0] b);
    logic [W-1:0] r;
    r = REFLECT ? c ^ W'(b) : c ^ (W'(b) << (W - 8));
    for (int i = 0; i < 8; i++)
      r = REFLECT ? (r[0] ? (r >> 1) ^ RP : r >> 1) : (r[W-1] ? (r << 1) ^ P : r << 1);
    return r;
  endfunction
  function automatic logic [7:0] crc_byte(input logic [W-1:0] c, input int k);
    logic [W-1:0] s;
    s = REFLECT ? (c ^ XO) >> (8 * k) : (c ^ XO) >> (W - 8 - 8 * k);
    return s[7:0];
  endfunction
  typedef enum logic [2:0] {S_WAITIDLE, S_IDLE, S_DATA, S_PAD, S_CRC} state_t;
  state_t              state;
  logic [W-1:0]        crc;
  logic [LGMAXLEN-1:0] count;
  logic [IW-1:0]       idx;
  logic                en_r;
  always_ff @(posedge i_clk) begin
    o_overrun <= 1'b0;
`ifdef CRC_APPEND_STATUS_EN
    o_done <= 1'b0;
`endif
    if (!i_reset_n) begin
      state  <= S_WAITIDLE;
      crc    <= I;
      count  <= '0;
      idx    <= '0;
      en_r   <= 1'b0;
      o_v    <= 1'b0;
      o_d    <= 8'h00;
      o_busy <= 1'b0;
`ifdef CRC_APPEND_STATUS_EN
      o_len  <= '0;
`endif
    end else if (i_ce) begin
      case (state)
        S_WAITIDLE: begin
          o_v <= 1'b0;
          if (!i_v) state <= S_IDLE;
        end
        S_IDLE: begin
          o_v <= i_v;
          if (i_v) begin
            en_r  <= i_en;
            o_d   <= i_d;
            crc   <= crc_upd(I, i_d);
            count <= LGMAXLEN'(1);
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (i_v) begin
            o_v   <= 1'b1;
            o_d   <= i_d;
            crc   <= crc_upd(crc, i_d);
            count <= (count == '1) ? count : count + 1'b1;
          end else if (!en_r) begin
            o_v   <= 1'b0;
            state <= S_IDLE;
`ifdef CRC_APPEND_STATUS_EN
            o_done <= 1'b1;
            o_len  <= count;
`endif
          end else if (int'(count) < MIN_PAYLOAD) begin
            o_v    <= 1'b1;
            o_d    <= 8'h00;
            crc    <= crc_upd(crc, 8'h00);
            count  <= count + 1'b1;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= (int'(count) + 1 >= MIN_PAYLOAD) ? S_CRC : S_PAD;
          end else begin
            o_v    <= 1'b1;
            o_d    <= crc_byte(crc, 0);
            idx    <= IW'(1);
            o_busy <= 1'b1;
            state  <= S_CRC;
`ifdef CRC_APPEND_STATUS_EN
            if (NB == 1) begin
              o_done <= 1'b1;
              o_len  <= count;
            end
`endif
          end
        end
        S_PAD: begin
          o_overrun <= i_v;
          o_v       <= 1'b1;
          o_d       <= 8'h00;
          crc       <= crc_upd(crc, 8'h00);
          count     <= count + 1'b1;
          idx       <= '0;
          state     <= (int'(count) + 1 >= MIN_PAYLOAD) ? S_CRC : S_PAD;
        end
        S_CRC: begin
          o_overrun <= i_v;
          if (idx == IW'(NB)) begin
            // a byte arriving here belongs to a packet already under way, so skip it entirely
            o_v    <= 1'b0;
            o_busy <= 1'b0;
            state  <= i_v ? S_WAITIDLE : S_IDLE;
          end else begin
            o_v <= 1'b1;
            o_d <= crc_byte(crc, int'(idx));
            idx <= idx + 1'b1;
`ifdef CRC_APPEND_STATUS_EN
            if (int'(idx) == NB - 1) begin
              o_done <= 1'b1;
              o_len  <= count;
            end
`endif
          end
        end
        default: state <= S_WAITIDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_append.sv
// tb_crc_append: directed checks of crc_append with default, no-pad and CRC-16 instances
module tb_crc_append;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, en = 1'b1, v = 1'b0;
  logic [7:0] d = 8'h00;
  logic a_v, b_v, c_v, a_busy, b_busy, c_busy, a_ovr, b_ovr, c_ovr;
  logic [7:0] a_d, b_d, c_d;
`ifdef CRC_APPEND_STATUS_EN
  logic a_done, b_done, c_done;
  logic [10:0] a_len, b_len, c_len;
`endif
  int total = 0, passed = 0;
  int busy_a, busy_b, ovr_a, run_a, max_run_a;
  logic [7:0] qa[$], qb[$], qc[$], pkt[$], exp_q[$];
  logic [7:0] got;
  always #5 clk = ~clk;
  crc_append u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_en(en), .i_v(v), .i_d(d),
    .o_v(a_v), .o_d(a_d), .o_busy(a_busy), .o_overrun(a_ovr)
`ifdef CRC_APPEND_STATUS_EN
    , .o_done(a_done), .o_len(a_len)
`endif
  );
  crc_append #(.MIN_PAYLOAD(0)) u_np (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_en(en), .i_v(v), .i_d(d),
    .o_v(b_v), .o_d(b_d), .o_busy(b_busy), .o_overrun(b_ovr)
`ifdef CRC_APPEND_STATUS_EN
    , .o_done(b_done), .o_len(b_len)
`endif
  );
  crc_append #(.CRC_BITS(16), .POLY(32'h1021), .INIT(32'hffff), .XOROUT(32'h0), .REFLECT(1'b0), .MIN_PAYLOAD(0)) u_c16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_en(en), .i_v(v), .i_d(d),
    .o_v(c_v), .o_d(c_d), .o_busy(c_busy), .o_overrun(c_ovr)
`ifdef CRC_APPEND_STATUS_EN
    , .o_done(c_done), .o_len(c_len)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    qa.delete(); qb.delete(); qc.delete();
    busy_a = 0; busy_b = 0; ovr_a = 0; run_a = 0; max_run_a = 0;
  endtask
  task automatic drive(input logic vv, input logic [7:0] dd);
    v = vv;
    d = dd;
    tick();
    if (a_v) qa.push_back(a_d);
    if (b_v) qb.push_back(b_d);
    if (c_v) qc.push_back(c_d);
    busy_a += int'(a_busy);
    busy_b += int'(b_busy);
    ovr_a += int'(a_ovr);
    run_a = a_v ? run_a + 1 : 0;
    if (run_a > max_run_a) max_run_a = run_a;
  endtask
  task automatic send_pkt(input int idle);
    foreach (pkt[i]) drive(1'b1, pkt[i]);
    repeat (idle) drive(1'b0, 8'h00);
  endtask
  task automatic build_exp(input int minp);
    logic [31:0] c;
    exp_q = pkt;
    while (exp_q.size() < minp) exp_q.push_back(8'h00);
    c = 32'hffff_ffff;
    foreach (exp_q[i]) begin
      c ^= {24'h0, exp_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hedb8_8320 : c >> 1;
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(c >> (8 * k)));
  endtask
  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; v = 1'b0; en = 1'b1;
    tick(); tick();
    total++; if (a_v !== 1'b0) $display("FAIL reset_o_v got %b want 0", a_v); else passed++;
    total++; if (a_d !== 8'h00) $display("FAIL reset_o_d got %h want 00", a_d); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL reset_o_busy got %b want 0", a_busy); else passed++;
    total++; if (a_ovr !== 1'b0) $display("FAIL reset_o_overrun got %b want 0", a_ovr); else passed++;
    rst_n = 1'b1;
    tick(); tick();
    total++; if (a_v !== 1'b0) $display("FAIL post_reset_o_v got %b want 0", a_v); else passed++;
  endtask
  task automatic test_crc32_nopad();
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    exp_q = pkt;
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hf4); exp_q.push_back(8'hcb);
    clear();
    send_pkt(70);
    total++; if (qb.size() !== 13) $display("FAIL crc32_len got %0d want 13", qb.size()); else passed++;
    for (int i = 0; i < 13; i++) begin
      got = (i < qb.size()) ? qb[i] : 8'hxx;
      total++; if (got !== exp_q[i]) $display("FAIL crc32_byte%0d got %h want %h", i, got, exp_q[i]); else passed++;
    end
    total++; if (busy_b !== 4) $display("FAIL crc32_busy_cycles got %0d want 4", busy_b); else passed++;
    total++; if (b_v !== 1'b0) $display("FAIL crc32_end_o_v got %b want 0", b_v); else passed++;
  endtask
  task automatic test_crc16();
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    exp_q = pkt;
    exp_q.push_back(8'h29); exp_q.push_back(8'hb1);
    clear();
    send_pkt(70);
    total++; if (qc.size() !== 11) $display("FAIL crc16_len got %0d want 11", qc.size()); else passed++;
    for (int i = 0; i < 11; i++) begin
      got = (i < qc.size()) ? qc[i] : 8'hxx;
      total++; if (got !== exp_q[i]) $display("FAIL crc16_byte%0d got %h want %h", i, got, exp_q[i]); else passed++;
    end
  endtask
  task automatic test_pad();
    pkt = '{8'h01, 8'h02, 8'h03};
    build_exp(60);
    clear();
    send_pkt(70);
    total++; if (qa.size() !== 64) $display("FAIL pad_len got %0d want 64", qa.size()); else passed++;
    for (int i = 0; i < 64; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      total++; if (got !== exp_q[i]) $display("FAIL pad_byte%0d got %h want %h", i, got, exp_q[i]); else passed++;
    end
    total++; if (max_run_a !== 64) $display("FAIL pad_contiguous got %0d want 64", max_run_a); else passed++;
    total++; if (busy_a !== 61) $display("FAIL pad_busy_cycles got %0d want 61", busy_a); else passed++;
  endtask
  task automatic test_passthru_ce();
    logic [7:0] pl [5];
    logic hv;
    logic [7:0] hd;
    pl[0] = 8'ha1; pl[1] = 8'hb2; pl[2] = 8'hc3; pl[3] = 8'hd4; pl[4] = 8'he5;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce = 1'b1;
      v = (i < 5);
      d = (i < 5) ? pl[i] : 8'h00;
      tick();
      if (i < 5) begin
        total++; if ({a_v, a_d} !== {1'b1, pl[i]}) $display("FAIL pass_byte%0d got v=%b d=%h want v=1 d=%h", i, a_v, a_d, pl[i]); else passed++;
      end else begin
        total++; if (a_v !== 1'b0) $display("FAIL pass_end_o_v got %b want 0", a_v); else passed++;
      end
      hv = a_v;
      hd = a_d;
      ce = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        total++; if ({a_v, a_d, a_busy} !== {hv, hd, 1'b0}) $display("FAIL pass_hold%0d_%0d got v=%b d=%h busy=%b want v=%b d=%h busy=0", i, j, a_v, a_d, a_busy, hv, hd); else passed++;
      end
    end
    ce = 1'b1;
    en = 1'b1;
    v = 1'b0;
    tick(); tick();
  endtask
  task automatic test_overrun();
    pkt.delete();
    for (int i = 0; i < 64; i++) pkt.push_back(8'(i + 1));
    build_exp(60);
    clear();
    foreach (pkt[i]) drive(1'b1, pkt[i]);
    drive(1'b0, 8'h00);
    repeat (6) drive(1'b1, 8'hee);
    repeat (70) drive(1'b0, 8'h00);
    total++; if (ovr_a !== 4) $display("FAIL overrun_pulses got %0d want 4", ovr_a); else passed++;
    total++; if (qa.size() !== 68) $display("FAIL overrun_len got %0d want 68", qa.size()); else passed++;
    for (int i = 64; i < 68; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      total++; if (got !== exp_q[i]) $display("FAIL overrun_crc%0d got %h want %h", i - 64, got, exp_q[i]); else passed++;
    end
  endtask
  task automatic test_reset_mid();
    clear();
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h80 + 8'(i));
    rst_n = 1'b0;
    v = 1'b1;
    d = 8'h55;
    tick();
    total++; if (a_v !== 1'b0) $display("FAIL midreset_o_v got %b want 0", a_v); else passed++;
    rst_n = 1'b1;
    clear();
    repeat (3) drive(1'b1, 8'h66);
    total++; if (qa.size() !== 0) $display("FAIL midreset_no_output got %0d bytes want 0", qa.size()); else passed++;
    drive(1'b0, 8'h00);
    pkt = '{8'h10, 8'h20, 8'h30};
    build_exp(60);
    clear();
    send_pkt(70);
    total++; if (qa.size() !== 64) $display("FAIL midreset_next_len got %0d want 64", qa.size()); else passed++;
    for (int i = 60; i < 64; i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      total++; if (got !== exp_q[i]) $display("FAIL midreset_next_crc%0d got %h want %h", i - 60, got, exp_q[i]); else passed++;
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_crc32_nopad();
    test_crc16();
    test_pad();
    test_passthru_ce();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
